// File: rtl/taxi_qsfp_ctrl_pkg.sv
// Shared types and helpers for the per-port QSFP28 sideband sequencer.
package taxi_qsfp_ctrl_pkg;

    typedef enum logic [2:0] {
        StAbsent   = 3'd0,
        StDebounce = 3'd1,
        StReset    = 3'd2,
        StInit     = 3'd3,
        StReady    = 3'd4
    } qsfp_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/taxi_qsfp_port_fsm.sv
// Single-port QSFP28 insertion/reset/init sequencer with registered sideband outputs.
module taxi_qsfp_port_fsm
    import taxi_qsfp_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 125000,
    parameter int unsigned RESET_CYC    = 1250,
    parameter int unsigned INIT_CYC     = 250000000,
    parameter int unsigned CNT_W        = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic i_prs,
    input  logic i_int,
    input  logic i_sw_reset,
    input  logic i_cfg_lpmode,
    output logic o_resetl,
    output logic o_lpmode,
    output logic o_present,
    output logic o_ready,
    output logic o_irq,
    output logic o_event
);

    localparam logic [CNT_W-1:0] LdDebounce = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LdReset    = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] LdInit     = CNT_W'(INIT_CYC - 1);

    qsfp_state_t      r_state, r_state_prev, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_cnt_zero;
    logic             w_sw_restart;

    assign w_cnt_zero   = (r_cnt == '0);
    assign w_sw_restart = i_sw_reset && (r_state inside {StReset, StInit, StReady});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        // Removal wins over both sw_reset and counter expiry.
        if (!i_prs) begin
            w_state_nxt = StAbsent;
            w_cnt_nxt   = '0;
        end else if (w_sw_restart) begin
            w_state_nxt = StReset;
            w_cnt_nxt   = LdReset;
        end else begin
            case (r_state)
                StAbsent: begin
                    w_state_nxt = StDebounce;
                    w_cnt_nxt   = LdDebounce;
                end
                StDebounce: if (w_cnt_zero) begin
                    w_state_nxt = StReset;
                    w_cnt_nxt   = LdReset;
                end
                StReset: if (w_cnt_zero) begin
                    w_state_nxt = StInit;
                    w_cnt_nxt   = LdInit;
                end
                StInit: if (w_cnt_zero) begin
                    w_state_nxt = StReady;
                end
                StReady: ;
                default: begin
                    w_state_nxt = StAbsent;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StAbsent;
            r_state_prev <= StAbsent;
            r_cnt        <= '0;
            o_resetl     <= 1'b0;
            o_lpmode     <= 1'b1;
            o_present    <= 1'b0;
            o_ready      <= 1'b0;
            o_irq        <= 1'b0;
            o_event      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_state_prev <= r_state;
            r_cnt        <= w_cnt_nxt;
            o_resetl     <= (r_state == StInit) || (r_state == StReady);
            o_lpmode     <= (r_state == StReady) ? i_cfg_lpmode : 1'b1;
            o_present    <= r_state inside {StReset, StInit, StReady};
            o_ready      <= (r_state == StReady);
            // IntL is only trusted once the module has finished its init window.
            o_irq        <= i_int && (r_state == StReady);
            o_event      <= (r_state != r_state_prev);
        end
    end

endmodule

// File: rtl/taxi_qsfp_port_ctrl.sv
// QSFP28 sideband controller: input synchronizers, per-port sequencers, ModSelL arbitration.
module taxi_qsfp_port_ctrl
    import taxi_qsfp_ctrl_pkg::*;
#(
    parameter int unsigned PORT_CNT     = 2,
    parameter int unsigned DEBOUNCE_CYC = 125000,
    parameter int unsigned RESET_CYC    = 1250,
    parameter int unsigned INIT_CYC     = 250000000,
    parameter int unsigned CNT_W        = $clog2(max3(DEBOUNCE_CYC, RESET_CYC, INIT_CYC) + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_CNT-1:0] eth_port_modprsl,
    input  logic [PORT_CNT-1:0] eth_port_intl,
    output logic [PORT_CNT-1:0] eth_port_resetl,
    output logic [PORT_CNT-1:0] eth_port_lpmode,
    output logic [PORT_CNT-1:0] eth_port_modsell,
    input  logic [PORT_CNT-1:0] cfg_lpmode,
    input  logic [PORT_CNT-1:0] sel_port,
    input  logic [PORT_CNT-1:0] sw_reset,
    output logic [PORT_CNT-1:0] port_present,
    output logic [PORT_CNT-1:0] port_ready,
    output logic [PORT_CNT-1:0] port_irq,
    output logic [PORT_CNT-1:0] port_event
);

    logic [PORT_CNT-1:0] r_prs_meta, r_prs, r_int_meta, r_int;
    logic [PORT_CNT-1:0] r_modsell;
    logic [PORT_CNT-1:0] w_sel_lsb;

    // Keep only the lowest requested port so at most one ModSelL is ever low.
    assign w_sel_lsb = sel_port & (~sel_port + PORT_CNT'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prs_meta <= '0;
            r_prs      <= '0;
            r_int_meta <= '0;
            r_int      <= '0;
            r_modsell  <= '1;
        end else begin
            r_prs_meta <= ~eth_port_modprsl;
            r_prs      <= r_prs_meta;
            r_int_meta <= ~eth_port_intl;
            r_int      <= r_int_meta;
            r_modsell  <= ~(w_sel_lsb & port_present);
        end
    end

    assign eth_port_modsell = r_modsell;

    for (genvar gi = 0; gi < PORT_CNT; gi++) begin : g_port
        taxi_qsfp_port_fsm #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .RESET_CYC    (RESET_CYC),
            .INIT_CYC     (INIT_CYC),
            .CNT_W        (CNT_W)
        ) u_port_fsm (
            .clk          (clk),
            .rst          (rst),
            .i_prs        (r_prs[gi]),
            .i_int        (r_int[gi]),
            .i_sw_reset   (sw_reset[gi]),
            .i_cfg_lpmode (cfg_lpmode[gi]),
            .o_resetl     (eth_port_resetl[gi]),
            .o_lpmode     (eth_port_lpmode[gi]),
            .o_present    (port_present[gi]),
            .o_ready      (port_ready[gi]),
            .o_irq        (port_irq[gi]),
            .o_event      (port_event[gi])
        );
    end

endmodule

// File: tb/tb_taxi_qsfp_port_ctrl.sv
// Bench for taxi_qsfp_port_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_taxi_qsfp_port_ctrl;

    localparam int D = 4;
    localparam int R = 10;
    localparam int I = 20;
    localparam int ABS = 0, DEB = 1, RST = 2, INI = 3, RDY = 4;

    logic       clk, rst;
    logic [1:0] modprsl, intl, cfg_lpmode, sel_port, sw_reset;
    logic [1:0] resetl, lpmode, modsell, present, ready, irq, evt;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    taxi_qsfp_port_ctrl #(
        .PORT_CNT     (2),
        .DEBOUNCE_CYC (D),
        .RESET_CYC    (R),
        .INIT_CYC     (I)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .eth_port_modprsl (modprsl),
        .eth_port_intl    (intl),
        .eth_port_resetl  (resetl),
        .eth_port_lpmode  (lpmode),
        .eth_port_modsell (modsell),
        .cfg_lpmode       (cfg_lpmode),
        .sel_port         (sel_port),
        .sw_reset         (sw_reset),
        .port_present     (present),
        .port_ready       (ready),
        .port_irq         (irq),
        .port_event       (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a port's state is a function of when presence started and when the
    // latest reset window began; inputs reach the sequencer two edges late.
    int         m_cyc;
    int         m_st[2], m_st_old[2], m_ins[2], m_rs[2];
    logic [1:0] m_p1, m_p2, m_i1, m_i2, m_p, m_q, m_sel;
    logic [1:0] e_resetl, e_lpmode, e_modsell, e_present, e_ready, e_irq, e_event;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cyc = 0;
            m_p1 = '0; m_p2 = '0; m_i1 = '0; m_i2 = '0;
            for (int i = 0; i < 2; i++) begin
                m_st[i] = ABS; m_st_old[i] = ABS; m_ins[i] = 0; m_rs[i] = 0;
            end
            e_resetl = 2'b00; e_lpmode = 2'b11; e_modsell = 2'b11; e_present = 2'b00;
            e_ready = 2'b00; e_irq = 2'b00; e_event = 2'b00;
        end else begin
            m_cyc++;
            m_p = m_p2; m_q = m_i2;
            m_p2 = m_p1; m_p1 = ~modprsl;
            m_i2 = m_i1; m_i1 = ~intl;
            m_sel = sel_port[0] ? 2'b01 : (sel_port[1] ? 2'b10 : 2'b00);
            e_modsell = ~(m_sel & e_present);
            for (int i = 0; i < 2; i++) begin
                int old, nx;
                old = m_st[i];
                e_resetl[i]  = (old == INI) || (old == RDY);
                e_lpmode[i]  = (old == RDY) ? cfg_lpmode[i] : 1'b1;
                e_present[i] = (old == RST) || (old == INI) || (old == RDY);
                e_ready[i]   = (old == RDY);
                e_irq[i]     = m_q[i] && (old == RDY);
                e_event[i]   = (old != m_st_old[i]);
                if (!m_p[i]) begin
                    nx = ABS;
                end else begin
                    if (old == ABS) begin
                        m_ins[i] = m_cyc;
                        m_rs[i]  = m_cyc + D;
                    end else if (sw_reset[i] && old >= RST) begin
                        m_rs[i] = m_cyc;
                    end
                    if (m_cyc - m_ins[i] < D)          nx = DEB;
                    else if (m_cyc - m_rs[i] < R)      nx = RST;
                    else if (m_cyc - m_rs[i] < R + I)  nx = INI;
                    else                               nx = RDY;
                end
                m_st_old[i] = old;
                m_st[i]     = nx;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("model resetl", resetl, e_resetl);
            chk("model lpmode", lpmode, e_lpmode);
            chk("model modsell", modsell, e_modsell);
            chk("model present", present, e_present);
            chk("model ready", ready, e_ready);
            chk("model irq", irq, e_irq);
            chk("model event", evt, e_event);
        end
    end

    initial begin
        int f_rl, f_rdy, f_irq, n_ev, n_lo, n_lo2, n_pr, n_rh, lp_ret;
        bit lp_hi;
        rst = 1'b1; modprsl = 2'b11; intl = 2'b11; cfg_lpmode = 2'b11;
        sel_port = 2'b00; sw_reset = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resetl", resetl, 2'b00);
        chk("reset lpmode", lpmode, 2'b11);
        chk("reset modsell", modsell, 2'b11);
        chk("reset present", present, 2'b00);
        chk("reset ready", ready, 2'b00);
        chk("reset irq", irq, 2'b00);
        chk("reset event", evt, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        model_on = 1'b1;

        // Insert port 0; IntL goes low mid-init.
        @(negedge clk);
        modprsl[0] = 1'b0;
        f_rl = -1; f_rdy = -1; f_irq = -1; n_ev = 0; n_lo = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (resetl[0] && f_rl < 0) f_rl = k;
            if (ready[0] && f_rdy < 0) f_rdy = k;
            if (irq[0] && f_irq < 0) f_irq = k;
            if (evt[0]) n_ev++;
            if (present[0] && !resetl[0]) n_lo++;
            if (k == 25) intl[0] = 1'b0;
        end
        chk_int("insert resetl rise", f_rl, 18);
        chk_int("insert ready rise", f_rdy, 38);
        chk_int("insert ready after resetl", f_rdy - f_rl, I);
        chk_int("insert resetl low width", n_lo, R);
        chk_int("insert event count", n_ev, 4);
        chk_int("irq first at ready", f_irq, 38);

        // Port 1 bounce: present only 3 cycles.
        @(negedge clk);
        modprsl[1] = 1'b0;
        n_ev = 0; n_pr = 0; n_rh = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 3) modprsl[1] = 1'b1;
            if (evt[1]) n_ev++;
            if (present[1]) n_pr++;
            if (resetl[1]) n_rh++;
        end
        chk_int("bounce present cycles", n_pr, 0);
        chk_int("bounce resetl high cycles", n_rh, 0);
        chk_int("bounce event count", n_ev, 2);

        // sw_reset in READY with cfg_lpmode=0.
        @(negedge clk);
        cfg_lpmode[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("lpmode follows cfg", lpmode, 2'b10);
        sw_reset = 2'b01;
        n_lo = 0; n_lo2 = 0; lp_ret = -1; lp_hi = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) sw_reset = 2'b00;
            if (!resetl[0]) n_lo++;
            if (!ready[0]) n_lo2++;
            if (lpmode[0]) lp_hi = 1'b1;
            else if (lp_hi && lp_ret < 0) lp_ret = k;
        end
        chk_int("swrst resetl low", n_lo, R);
        chk_int("swrst ready low", n_lo2, R + I);
        chk_int("swrst lpmode return", lp_ret, 32);

        // Bring port 1 up, then arbitrate ModSelL.
        @(negedge clk);
        modprsl[1] = 1'b0;
        repeat (45) @(negedge clk);
        chk("both ready", ready, 2'b11);
        sel_port = 2'b11;
        @(negedge clk);
        chk("sel 11 modsell", modsell, 2'b10);
        sel_port = 2'b10;
        @(negedge clk);
        chk("sel 10 modsell", modsell, 2'b01);

        // Remove port 0, select it anyway.
        modprsl[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("removed present", present, 2'b10);
        sel_port = 2'b01;
        @(negedge clk);
        chk("sel absent modsell", modsell, 2'b11);

        // Re-insert, then remove 5 cycles into INIT.
        modprsl[0] = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 22) modprsl[0] = 1'b1;
            if (k == 25) begin
                chk("init rm resetl before", resetl, 2'b11);
                chk("init rm present before", present, 2'b11);
            end
            if (k == 26) begin
                chk("init rm resetl after", resetl, 2'b10);
                chk("init rm present after", present, 2'b10);
            end
        end

        // Full sequence restarts on re-insertion.
        repeat (10) @(negedge clk);
        modprsl[0] = 1'b0;
        f_rl = -1; f_rdy = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (resetl[0] && f_rl < 0) f_rl = k;
            if (ready[0] && f_rdy < 0) f_rdy = k;
        end
        chk_int("reinsert resetl rise", f_rl, 18);
        chk_int("reinsert ready rise", f_rdy, 38);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
